// File: rtl/serial_frame_deser_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | serial_frame_deser_if                                                  |
// | Serial bit stream in, framed parallel word and status out.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface serial_frame_deser_if #(
   parameter int WORD_W = 8
);
   logic              din_valid;
   logic              d_in;
   logic [WORD_W-1:0] word_out;
   logic              word_valid;
   logic              parity_err;
   logic              locked;
   logic [7:0]        frame_cnt;

   modport master (
      output din_valid, d_in,
      input  word_out, word_valid, parity_err, locked, frame_cnt
   );

   modport slave (
      input  din_valid, d_in,
      output word_out, word_valid, parity_err, locked, frame_cnt
   );
endinterface
`default_nettype wire

// File: rtl/serial_frame_deser.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | serial_frame_deser                                                     |
// | Hunts for a sync pattern, then captures one word plus even parity.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module serial_frame_deser #(
   parameter int                WORD_W   = 8,
   parameter int                SYNC_W   = 8,
   parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5
) (
   input  wire logic           clock,
   input  wire logic           reset,
   serial_frame_deser_if.slave bus
);
   localparam int c_CNT_W = $clog2(WORD_W + 1);
   localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WORD_W - 1);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   state_t              r_state;
   logic [SYNC_W-1:0]   r_sync;
   logic [WORD_W-1:0]   r_data;
   logic [WORD_W-1:0]   r_word;
   logic [c_CNT_W-1:0]  r_bit_cnt;
   logic                r_par;
   logic                r_word_valid;
   logic                r_parity_err;
   logic                r_locked;
   logic [7:0]          r_frame_cnt;
   logic [SYNC_W-1:0]   w_sync_next;

   // Match is evaluated on the register including the bit being accepted.
   assign w_sync_next = {r_sync[SYNC_W-2:0], bus.d_in};

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= ST_HUNT;
         r_sync       <= '0;
         r_data       <= '0;
         r_word       <= '0;
         r_bit_cnt    <= '0;
         r_par        <= 1'b0;
         r_word_valid <= 1'b0;
         r_parity_err <= 1'b0;
         r_locked     <= 1'b0;
         r_frame_cnt  <= 8'd0;
      end else begin
         r_word_valid <= 1'b0;
         if (bus.din_valid) begin
            case (r_state)
               ST_HUNT: begin
                  r_sync <= w_sync_next;
                  if (w_sync_next == SYNC_PAT) begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= '0;
                     r_par     <= 1'b0;
                     r_locked  <= 1'b1;
                  end
               end
               ST_DATA: begin
                  r_data    <= {r_data[WORD_W-2:0], bus.d_in};
                  r_par     <= r_par ^ bus.d_in;
                  r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                  if (r_bit_cnt == c_LAST_BIT) begin
                     r_state <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  r_word       <= r_data;
                  r_parity_err <= (bus.d_in != r_par);
                  r_word_valid <= 1'b1;
                  r_frame_cnt  <= r_frame_cnt + 8'd1;
                  r_sync       <= '0;
                  r_locked     <= 1'b0;
                  r_state      <= ST_HUNT;
               end
               default: begin
                  r_state  <= ST_HUNT;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.word_out   = r_word;
   assign bus.word_valid = r_word_valid;
   assign bus.parity_err = r_parity_err;
   assign bus.locked     = r_locked;
   assign bus.frame_cnt  = r_frame_cnt;
endmodule
`default_nettype wire

// File: tb/tb_serial_frame_deser.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_serial_frame_deser                                                  |
// | Scoreboard bench for the sync-hunting frame deserializer.              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_serial_frame_deser;
   localparam logic [7:0] c_SYNC = 8'hA5;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   acc_cnt, n_valid, n_locked, valid_at;
   logic [7:0] model_cnt = 8'd0;
   logic [16:0] exp_q[$];

   always #5 clock = ~clock;

   serial_frame_deser_if #(.WORD_W(8)) bus ();

   serial_frame_deser #(.WORD_W(8), .SYNC_W(8), .SYNC_PAT(8'hA5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Drives one cycle; any word_valid seen is popped against the scoreboard.
   task automatic send_bit(input logic b, input logic v);
      logic [16:0] e;
      bus.d_in      = b;
      bus.din_valid = v;
      @(posedge clock);
      #1;
      if (v && reset) acc_cnt++;
      if (bus.locked === 1'b1) n_locked++;
      if (bus.word_valid === 1'b1) begin
         n_valid++;
         valid_at = acc_cnt;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: word_valid with word_out=%h cnt=%0d, required no word", bus.word_out, bus.frame_cnt);
         end else begin
            e = exp_q.pop_front();
            if ({bus.word_out, bus.parity_err, bus.frame_cnt} !== e) begin
               errors++;
               $display("FAIL sb_word: got word=%h perr=%b cnt=%0d, required word=%h perr=%b cnt=%0d",
                        bus.word_out, bus.parity_err, bus.frame_cnt, e[16:9], e[8], e[7:0]);
            end
         end
      end
   endtask

   task automatic send_acc(input logic b, input bit gap);
      if (gap) send_bit(1'($urandom_range(0, 1)), 1'b0);
      send_bit(b, 1'b1);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic par, input bit gap);
      model_cnt = model_cnt + 8'd1;
      exp_q.push_back({data, (par != ^data), model_cnt});
      for (int i = 7; i >= 0; i--) send_acc(c_SYNC[i], gap);
      for (int i = 7; i >= 0; i--) send_acc(data[i], gap);
      send_acc(par, gap);
   endtask

   task automatic clear_stats();
      acc_cnt = 0; n_valid = 0; n_locked = 0; valid_at = -1;
   endtask

   task automatic test_reset();
      clear_stats();
      reset = 1'b0;
      send_bit(1'($urandom_range(0, 1)), 1'b1);
      send_bit(1'($urandom_range(0, 1)), 1'b1);
      model_cnt = 8'd0;
      checks++; if (bus.word_out !== 8'h00) begin errors++; $display("FAIL rst_word_out: got %h, required 00", bus.word_out); end
      checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL rst_word_valid: got %b, required 0", bus.word_valid); end
      checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL rst_parity_err: got %b, required 0", bus.parity_err); end
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b, required 0", bus.locked); end
      checks++; if (bus.frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d, required 0", bus.frame_cnt); end
      reset = 1'b1;
   endtask

   task automatic test_clean_frame();
      clear_stats();
      send_frame(8'h3C, 1'b0, 1'b0);
      checks++; if (n_valid != 1) begin errors++; $display("FAIL clean_valid_count: got %0d, required 1", n_valid); end
      checks++; if (n_locked != 9) begin errors++; $display("FAIL clean_locked_cycles: got %0d, required 9", n_locked); end
      checks++; if (bus.frame_cnt !== 8'd1) begin errors++; $display("FAIL clean_frame_cnt: got %0d, required 1", bus.frame_cnt); end
      send_bit(1'b1, 1'b0);
      checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL clean_pulse_width: got %b, required 0", bus.word_valid); end
      checks++; if (bus.word_out !== 8'h3C) begin errors++; $display("FAIL clean_word_hold: got %h, required 3c", bus.word_out); end
   endtask

   task automatic test_parity_overlap();
      logic [3:0] junk = 4'b1010;
      logic [7:0] data = 8'hC1;
      clear_stats();
      for (int i = 3; i >= 0; i--) send_bit(junk[i], 1'b1);
      for (int i = 7; i >= 1; i--) send_bit(c_SYNC[i], 1'b1);
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL ovl_early_lock: got %b, required 0", bus.locked); end
      model_cnt = model_cnt + 8'd1;
      exp_q.push_back({data, 1'b1, model_cnt});
      send_bit(c_SYNC[0], 1'b1);
      checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL ovl_lock: got %b, required 1", bus.locked); end
      for (int i = 7; i >= 0; i--) send_bit(data[i], 1'b1);
      send_bit(1'b0, 1'b1);
      checks++; if (bus.parity_err !== 1'b1) begin errors++; $display("FAIL ovl_parity_err: got %b, required 1", bus.parity_err); end
      checks++; if (n_valid != 1) begin errors++; $display("FAIL ovl_valid_count: got %0d, required 1", n_valid); end
      send_bit(1'b0, 1'b0);
      checks++; if (bus.parity_err !== 1'b1) begin errors++; $display("FAIL ovl_perr_hold: got %b, required 1", bus.parity_err); end
   endtask

   task automatic test_valid_gaps();
      clear_stats();
      send_frame(8'h3C, 1'b0, 1'b1);
      checks++; if (valid_at != 17) begin errors++; $display("FAIL gap_valid_at: got bit %0d, required 17", valid_at); end
      checks++; if (n_valid != 1) begin errors++; $display("FAIL gap_valid_count: got %0d, required 1", n_valid); end
      checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL gap_parity_err: got %b, required 0", bus.parity_err); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] data = 8'h5A;
      clear_stats();
      for (int i = 7; i >= 0; i--) send_bit(c_SYNC[i], 1'b1);
      for (int i = 7; i >= 4; i--) send_bit(data[i], 1'b1);
      reset = 1'b0;
      send_bit(1'b1, 1'b1);
      model_cnt = 8'd0;
      reset = 1'b1;
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL mid_locked: got %b, required 0", bus.locked); end
      checks++; if (bus.word_out !== 8'h00) begin errors++; $display("FAIL mid_word_out: got %h, required 00", bus.word_out); end
      send_frame(data, 1'b0, 1'b0);
      checks++; if (n_valid != 1) begin errors++; $display("FAIL mid_valid_count: got %0d, required 1", n_valid); end
      checks++; if (bus.frame_cnt !== 8'd1) begin errors++; $display("FAIL mid_frame_cnt: got %0d, required 1", bus.frame_cnt); end
   endtask

   task automatic test_sync_in_data_wrap();
      bit seen_zero = 1'b0;
      clear_stats();
      reset = 1'b0;
      send_bit(1'b0, 1'b1);
      model_cnt = 8'd0;
      reset = 1'b1;
      send_frame(8'hA5, 1'b0, 1'b0);
      checks++; if (n_valid != 1) begin errors++; $display("FAIL sid_valid_count: got %0d, required 1", n_valid); end
      checks++; if (bus.word_out !== 8'hA5) begin errors++; $display("FAIL sid_word_out: got %h, required a5", bus.word_out); end
      for (int f = 0; f < 256; f++) begin
         send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
         if (model_cnt == 8'd0) begin
            seen_zero = 1'b1;
            checks++;
            if (bus.frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d, required 0", bus.frame_cnt); end
         end
      end
      checks++; if (!seen_zero) begin errors++; $display("FAIL wrap_seen: got no zero count, required one"); end
      checks++; if (n_valid != 257) begin errors++; $display("FAIL wrap_valid_count: got %0d, required 257", n_valid); end
      checks++; if (bus.frame_cnt !== 8'd1) begin errors++; $display("FAIL wrap_final_cnt: got %0d, required 1", bus.frame_cnt); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
   endtask

   initial begin
      bus.din_valid = 1'b0;
      bus.d_in      = 1'b0;
      test_reset();
      test_clean_frame();
      test_parity_overlap();
      test_valid_gaps();
      test_reset_midframe();
      test_sync_in_data_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
